// File: rtl/objects_mux_layered.sv
// Layered VGA object mux: per-pixel priority select over NUM_OBJ layers plus background,
// with colour-key transparency, runtime layer enables and per-frame player collision report.
module objects_mux_layered #(
    parameter int               NUM_OBJ     = 12,
    parameter int               RGB_W       = 8,
    parameter logic [RGB_W-1:0] TRANSPARENT = 8'hFF,
    parameter int               IDX_W       = $clog2(NUM_OBJ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            startOfFrame,
    input  logic [NUM_OBJ-1:0]              layerEnable,
    input  logic [NUM_OBJ-1:0]              drawingRequest,
    input  logic [NUM_OBJ-1:0][RGB_W-1:0]   objRGB,
    input  logic [RGB_W-1:0]                backGroundRGB,
    output logic [RGB_W-1:0]                RGBOut,
    output logic                            winnerValid,
    output logic [IDX_W-1:0]                winnerIdx,
    output logic [NUM_OBJ-1:0]              collisionPulse,
    output logic [NUM_OBJ-1:0]              frameCollisions
);

    logic [NUM_OBJ-1:0]            eff;
    logic [NUM_OBJ-1:0]            hit;
    logic [NUM_OBJ-1:0]            eff_q;
    logic [NUM_OBJ-1:0]            hit_q;
    logic [NUM_OBJ-1:0][RGB_W-1:0] rgb_q;
    logic [RGB_W-1:0]              bg_q;
    logic                          sof_q;
    logic [NUM_OBJ-1:0]            seen;

    logic [RGB_W-1:0]              win_rgb;
    logic                          win_valid;
    logic [IDX_W-1:0]              win_idx;

    // A layer only counts when requested, enabled and not showing the colour key.
    always_comb begin
        for (int i = 0; i < NUM_OBJ; i++) begin
            eff[i] = drawingRequest[i] & layerEnable[i] & (objRGB[i] != TRANSPARENT);
        end
        hit    = eff & {NUM_OBJ{eff[0]}};
        hit[0] = 1'b0;
    end

    // Stage 1: capture the qualified request vector and pixel data.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data registers are cleared too, so the first post-reset pixel is a defined background.
            eff_q <= '0;
            hit_q <= '0;
            rgb_q <= '0;
            bg_q  <= '0;
            sof_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            eff_q <= eff;
            hit_q <= hit;
            rgb_q <= objRGB;
            bg_q  <= backGroundRGB;
            sof_q <= startOfFrame;
        end
    end

    // Descending scan: the last assignment wins, so the lowest set index takes priority.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        win_rgb   = bg_q;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (eff_q[i]) begin
                win_rgb   = rgb_q[i];
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    // Stage 2: registered outputs and per-frame sticky collision tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            RGBOut          <= '0;
            winnerValid     <= 1'b0;
            winnerIdx       <= '0;
            collisionPulse  <= '0;
            frameCollisions <= '0;
            seen            <= '0;
        end else begin
            RGBOut      <= win_rgb;
            winnerValid <= win_valid;
            winnerIdx   <= win_idx;
            if (sof_q) begin
                // The first pixel of the new frame already belongs to the new frame.
                frameCollisions <= seen;
                seen            <= hit_q;
                collisionPulse  <= hit_q;
            end else begin
                seen            <= seen | hit_q;
                collisionPulse  <= hit_q & ~seen;
            end
        end
    end

endmodule

// File: tb/tb_objects_mux_layered.sv
// Self-checking bench for objects_mux_layered: directed scenarios plus a randomized run
// compared against a pixel/frame level reference model.
module tb_objects_mux_layered;

    localparam int N = 12;

    logic                clk;
    logic                reset;
    logic                startOfFrame;
    logic [N-1:0]        layerEnable;
    logic [N-1:0]        drawingRequest;
    logic [N-1:0][7:0]   objRGB;
    logic [7:0]          backGroundRGB;
    logic [7:0]          RGBOut;
    logic                winnerValid;
    logic [3:0]          winnerIdx;
    logic [N-1:0]        collisionPulse;
    logic [N-1:0]        frameCollisions;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the pixel sampled on the previous edge, the expected
    // outputs, and the set of layers that have touched the player this frame.
    logic              p_sof;
    logic [N-1:0]      p_req;
    logic [N-1:0]      p_en;
    logic [N-1:0][7:0] p_rgb;
    logic [7:0]        p_bg;
    logic [7:0]        exp_rgb;
    logic              exp_valid;
    logic [3:0]        exp_idx;
    logic [N-1:0]      exp_pulse;
    logic [N-1:0]      exp_fc;
    logic [N-1:0]      m_seen;

    objects_mux_layered dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .layerEnable     (layerEnable),
        .drawingRequest  (drawingRequest),
        .objRGB          (objRGB),
        .backGroundRGB   (backGroundRGB),
        .RGBOut          (RGBOut),
        .winnerValid     (winnerValid),
        .winnerIdx       (winnerIdx),
        .collisionPulse  (collisionPulse),
        .frameCollisions (frameCollisions)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic drawn(input logic [N-1:0] req, input logic [N-1:0] en,
                                   input logic [N-1:0][7:0] rgb, input int i);
        return req[i] && en[i] && (rgb[i] != 8'hFF);
    endfunction

    function automatic void ref_select(input logic [N-1:0] req, input logic [N-1:0] en,
                                       input logic [N-1:0][7:0] rgb, input logic [7:0] bg,
                                       output logic [7:0] c, output logic v, output logic [3:0] idx);
        c = bg; v = 1'b0; idx = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (drawn(req, en, rgb, i)) begin
                c = rgb[i]; v = 1'b1; idx = 4'(i);
                break;
            end
        end
    endfunction

    function automatic logic [N-1:0] ref_overlap(input logic [N-1:0] req, input logic [N-1:0] en,
                                                  input logic [N-1:0][7:0] rgb);
        logic [N-1:0] o;
        o = '0;
        if (drawn(req, en, rgb, 0))
            for (int i = 1; i < N; i++)
                if (drawn(req, en, rgb, i)) o[i] = 1'b1;
        return o;
    endfunction

    // One clock: update the model with the pixel sampled on this edge, then move to the negedge.
    task automatic step();
        logic [N-1:0] ov;
        @(posedge clk);
        if (reset) begin
            exp_rgb = '0; exp_valid = 1'b0; exp_idx = '0; exp_pulse = '0; exp_fc = '0; m_seen = '0;
            p_sof = 1'b0; p_req = '0; p_en = '0; p_rgb = '0; p_bg = '0;
        end else begin
            ref_select(p_req, p_en, p_rgb, p_bg, exp_rgb, exp_valid, exp_idx);
            ov = ref_overlap(p_req, p_en, p_rgb);
            if (p_sof) begin
                exp_fc    = m_seen;
                m_seen    = ov;
                exp_pulse = ov;
            end else begin
                exp_pulse = ov & ~m_seen;
                m_seen    = m_seen | ov;
            end
            p_sof = startOfFrame; p_req = drawingRequest; p_en = layerEnable;
            p_rgb = objRGB;       p_bg  = backGroundRGB;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic sof);
        startOfFrame   = sof;
        layerEnable    = '1;
        drawingRequest = '0;
        objRGB         = '0;
        backGroundRGB  = 8'h12;
    endtask

    task automatic overlap(input logic sof, input int layer);
        idle(sof);
        drawingRequest = '0;
        drawingRequest[0]     = 1'b1;
        drawingRequest[layer] = 1'b1;
        objRGB[0]     = 8'h11;
        objRGB[layer] = 8'h22;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        startOfFrame = 1'b0; layerEnable = '0; drawingRequest = '0; objRGB = '0; backGroundRGB = 8'h12;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if ({RGBOut, winnerValid, winnerIdx, collisionPulse, frameCollisions} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: rgb=%h valid=%b idx=%0d pulse=%h fc=%h, required all 0",
                         k, RGBOut, winnerValid, winnerIdx, collisionPulse, frameCollisions);
            end
        end
        reset = 1'b0;
        step();
        step();
        n_tests++;
        if (RGBOut !== 8'h12 || winnerValid !== 1'b0 || winnerIdx !== 4'd0 ||
            collisionPulse !== '0 || frameCollisions !== '0) begin
            n_fail++;
            $display("FAIL reset_first_pixel: rgb=%h valid=%b idx=%0d pulse=%h fc=%h, required rgb=12 others 0",
                     RGBOut, winnerValid, winnerIdx, collisionPulse, frameCollisions);
        end
    endtask

    task automatic run_pair(input string name, input logic [N-1:0] en, input logic [7:0] rgb3,
                            input logic [7:0] want_rgb, input logic [3:0] want_idx);
        idle(1'b0);
        layerEnable    = en;
        drawingRequest = 12'h028;
        objRGB[3]      = rgb3;
        objRGB[5]      = 8'h1C;
        step();
        idle(1'b0);
        n_tests++;
        if (RGBOut !== 8'h12 || winnerValid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_latency1: rgb=%h valid=%b, required rgb=12 valid=0", name, RGBOut, winnerValid);
        end
        step();
        n_tests++;
        if (RGBOut !== want_rgb || winnerIdx !== want_idx || winnerValid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: rgb=%h idx=%0d valid=%b, required rgb=%h idx=%0d valid=1",
                     name, RGBOut, winnerIdx, winnerValid, want_rgb, want_idx);
        end
        step();
    endtask

    task automatic test_priority();
        run_pair("priority",    '1,                8'hA0, 8'hA0, 4'd3);
        run_pair("disabled_l3", 12'hFFF & ~12'h008, 8'hA0, 8'h1C, 4'd5);
        run_pair("transp_l3",   '1,                8'hFF, 8'h1C, 4'd5);
    endtask

    task automatic test_collision_span();
        idle(1'b1); step();
        idle(1'b0); step(); step();
        for (int k = 0; k < 8; k++) begin
            if (k < 4) overlap(1'b0, 7); else idle(1'b0);
            step();
            n_tests++;
            if (collisionPulse !== ((k == 1) ? 12'h080 : 12'h000)) begin
                n_fail++;
                $display("FAIL span_pulse[%0d]: pulse=%h, required %h", k, collisionPulse,
                         (k == 1) ? 12'h080 : 12'h000);
            end
        end
        idle(1'b1); step();
        idle(1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            n_tests++;
            if (frameCollisions !== 12'h080) begin
                n_fail++;
                $display("FAIL span_frame[%0d]: fc=%h, required 080", k, frameCollisions);
            end
        end
    endtask

    task automatic test_sof_overlap();
        idle(1'b1); step();
        idle(1'b0); step(); step(); step();
        overlap(1'b1, 2); step();
        idle(1'b0); step();
        n_tests++;
        if (frameCollisions !== 12'h000 || collisionPulse !== 12'h004) begin
            n_fail++;
            $display("FAIL sof_overlap: fc=%h pulse=%h, required fc=000 pulse=004", frameCollisions, collisionPulse);
        end
        step(); step(); step();
        idle(1'b1); step();
        idle(1'b0); step();
        n_tests++;
        if (frameCollisions !== 12'h004) begin
            n_fail++;
            $display("FAIL sof_overlap_next: fc=%h, required 004", frameCollisions);
        end
    endtask

    task automatic test_reset_mid();
        idle(1'b1); step();
        idle(1'b0); step();
        overlap(1'b0, 4); step();
        idle(1'b0); step(); step();
        reset = 1'b1; step();
        n_tests++;
        if ({RGBOut, winnerValid, winnerIdx, collisionPulse, frameCollisions} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: rgb=%h valid=%b idx=%0d pulse=%h fc=%h, required all 0",
                     RGBOut, winnerValid, winnerIdx, collisionPulse, frameCollisions);
        end
        reset = 1'b0; step();
        idle(1'b1); step();
        idle(1'b0); step();
        n_tests++;
        if (frameCollisions !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_frame: fc=%h, required 000", frameCollisions);
        end
    endtask

    task automatic test_back_to_back();
        overlap(1'b1, 1); step();
        overlap(1'b1, 3); step();
        idle(1'b0); step();
        n_tests++;
        if (frameCollisions !== 12'h002) begin
            n_fail++;
            $display("FAIL back_to_back_sof: fc=%h, required 002", frameCollisions);
        end
        step();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 2000; c++) begin
            reset          = ($urandom_range(299) == 0);
            startOfFrame   = ($urandom_range(39) == 0);
            layerEnable    = N'($urandom) | N'($urandom);
            drawingRequest = N'($urandom) & N'($urandom);
            if ($urandom_range(2) == 0) drawingRequest[0] = 1'b1;
            for (int i = 0; i < N; i++)
                objRGB[i] = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
            backGroundRGB  = 8'($urandom);
            step();
            n_tests++;
            if (RGBOut !== exp_rgb || winnerValid !== exp_valid || winnerIdx !== exp_idx ||
                collisionPulse !== exp_pulse || frameCollisions !== exp_fc) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: rgb=%h valid=%b idx=%0d pulse=%h fc=%h, required rgb=%h valid=%b idx=%0d pulse=%h fc=%h",
                             c, RGBOut, winnerValid, winnerIdx, collisionPulse, frameCollisions,
                             exp_rgb, exp_valid, exp_idx, exp_pulse, exp_fc);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_collision_span();
        test_sof_overlap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/objects_mux_layered.md
Name: objects_mux_layered

Overview:
- Parametrised successor to the fixed-priority VGA object mux.
- Selects one RGB per pixel from NUM_OBJ object layers plus background, with:
  - per-layer runtime enable;
  - colour-key transparency;
  - a 2-stage registered pipeline.
- Also detects pixel-level collisions between layer 0 (player) and every other layer, and reports them per frame.
- Sits between the object drawers and the VGA controller RGB input.

Parameters:
- NUM_OBJ, 12, number of object layers; legal range 2..32; index 0 = highest priority = player.
- RGB_W, 8, colour width.
- TRANSPARENT, 8'hFF, colour key; a pixel of this value is never drawn and never collides.
- IDX_W, $clog2(NUM_OBJ), width of winnerIdx (derived; do not override).

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse, aligned with the first pixel of a frame
- layerEnable  in  NUM_OBJ  per-layer enable mask (1 = layer may draw)
- drawingRequest  in  NUM_OBJ  per-layer drawing request for the current pixel
- objRGB  in  NUM_OBJ x RGB_W  per-layer colour for the current pixel
- backGroundRGB  in  RGB_W  background colour, used when no layer wins
- RGBOut  out  RGB_W  selected colour, 2-cycle latency
- winnerValid  out  1  1 = some layer won; 0 = background shown
- winnerIdx  out  IDX_W  index of the winning layer; 0 when winnerValid=0
- collisionPulse  out  NUM_OBJ  bit i (i>=1) pulses once per frame on the first layer0/layer-i overlap; bit 0 always 0
- frameCollisions  out  NUM_OBJ  bit i = layer0/layer-i overlap occurred in the previous frame; bit 0 always 0

Behaviour:
- Reset (sampled on a clk edge while reset=1) clears:
  - RGBOut, winnerValid, winnerIdx, collisionPulse, frameCollisions;
  - all pipeline registers and sticky collision state.
- First valid output: 2 cycles after reset deasserts.
- Reset asserted mid-frame: state clears on the next edge; the frame in progress reports no collisions.
- Effective request, per layer i: eff[i] = drawingRequest[i] & layerEnable[i] & (objRGB[i] != TRANSPARENT).
- Stage 1 (cycle N+1) registers:
  - eff vector;
  - objRGB array;
  - backGroundRGB;
  - startOfFrame;
  - hit vector: hit[i] = eff[0] & eff[i] for i>=1, hit[0]=0.
- Stage 2 (cycle N+2), priority encode of registered eff:
  - lowest set index k wins: RGBOut=objRGB[k], winnerValid=1, winnerIdx=k;
  - no bit set: RGBOut=backGroundRGB, winnerValid=0, winnerIdx=0.
- Total latency from input sample to RGBOut: exactly 2 cycles; one pixel per cycle; no stalls.
- Sticky state seen[NUM_OBJ-1:0], updated in stage 2:
  - If registered startOfFrame=1:
    - frameCollisions <= seen;
    - seen <= hit (the new frame's first pixel counts);
    - collisionPulse <= hit.
  - Otherwise:
    - seen <= seen | hit;
    - collisionPulse <= hit & ~seen (one pulse per layer per frame, even if the overlap spans many pixels).
  - Update rule summary: frameCollisions changes only on registered startOfFrame and holds all frame.
- Disabled or transparent layers never win and never collide, including layer 0. A transparent layer-0 pixel lets lower layers show through.
- All bits set: layer 0 wins; collisionPulse may have multiple bits set in one cycle.
- startOfFrame on two consecutive cycles: each pulse performs the frame latch. The second latches seen, which then holds only the first pixel's hits.
- All logic is single-clock; no combinational path from any input to any output.

Test Plan:
- Reset held 3 cycles, then all inputs 0, backGroundRGB=8'h12 -> two cycles later RGBOut=8'h12, winnerValid=0, winnerIdx=0; all other outputs 0.
- drawingRequest=12'h028, layerEnable=all-1, objRGB[3]=8'hA0, objRGB[5]=8'h1C -> exactly 2 cycles later RGBOut=8'hA0, winnerIdx=3, winnerValid=1.
- Layer-3 suppression, same stimulus as the previous scenario:
  - with layerEnable[3]=0 -> RGBOut=8'h1C, winnerIdx=5;
  - instead with objRGB[3]=8'hFF -> same result.
- Layers 0 and 7 drawn together for 4 consecutive cycles mid-frame -> collisionPulse[7]=1 for exactly one cycle (2 cycles after the first overlap), then 0. At the next startOfFrame -> frameCollisions=12'h080, held for the whole following frame.
- startOfFrame coincident with a layer0/layer-2 overlap, previous frame clean -> frameCollisions=0, collisionPulse[2]=1 that cycle. At the following startOfFrame -> frameCollisions[2]=1.
- Reset asserted for 1 cycle after layer0/layer-4 overlap mid-frame -> all outputs 0. At the next startOfFrame -> frameCollisions=0.
